pll_lock_supervisor: RTL

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_sup_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_lock_supervisor.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: state encoding, default
// timing constants and the counter-width helper.
package pll_sup_pkg;

    localparam int RST_PULSE_CYC_DEF    = 16;
    localparam int LOCK_TIMEOUT_CYC_DEF = 65536;
    localparam int STABLE_CYC_DEF       = 1024;
    localparam int MAX_RETRY_DEF        = 3;

    typedef enum logic [2:0] {
        ST_PULSE  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAIL   = 3'd4
    } sup_state_t;

    // One spare bit over the load value so a down-count can never wrap unseen.
    function automatic int cnt_width(input int n);
        return $clog2((n < 2) ? 2 : n) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable lock and releases the downstream
// reset; retries a bounded number of times before parking in FAIL.
//
//   state  | meaning
//   PULSE  | PLL held in reset for RST_PULSE_CYC cycles
//   WAIT   | PLL released, waiting for synchronized lock (with timeout)
//   STABLE | lock seen, counting consecutive lock cycles
//   RUN    | lock stable, downstream reset released
//   FAIL   | retries exhausted, PLL held in reset until restart
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYC    = RST_PULSE_CYC_DEF,
    parameter int LOCK_TIMEOUT_CYC = LOCK_TIMEOUT_CYC_DEF,
    parameter int STABLE_CYC       = STABLE_CYC_DEF,
    parameter int MAX_RETRY        = MAX_RETRY_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       locked,
    output logic       fail,
    output logic [3:0] attempt
);

    localparam int PW = cnt_width(RST_PULSE_CYC);
    localparam int TW = cnt_width(LOCK_TIMEOUT_CYC);
    localparam int SW = cnt_width(STABLE_CYC);

    localparam logic [PW-1:0] PULSE_LOAD = PW'(RST_PULSE_CYC - 1);
    localparam logic [TW-1:0] TMO_LOAD   = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [SW-1:0] STB_LOAD   = SW'(STABLE_CYC - 1);
    localparam logic [PW-1:0] PULSE_ONE  = PW'(1);
    localparam logic [TW-1:0] TMO_ONE    = TW'(1);
    localparam logic [SW-1:0] STB_ONE    = SW'(1);
    localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRY);

    generate
        if (RST_PULSE_CYC < 1 || LOCK_TIMEOUT_CYC < 1 || STABLE_CYC < 1 ||
            MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_param
            $error("pll_lock_supervisor: parameter out of range");
        end
    endgenerate

    logic lock_s;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    sup_state_t    state, state_nxt;
    logic [PW-1:0] pulse_cnt, pulse_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic [SW-1:0] stb_cnt, stb_nxt;
    logic [3:0]    attempt_nxt;

    always_comb begin
        state_nxt   = state;
        pulse_nxt   = pulse_cnt;
        tmo_nxt     = tmo_cnt;
        stb_nxt     = stb_cnt;
        attempt_nxt = attempt;

        if (restart) begin
            state_nxt   = ST_PULSE;
            pulse_nxt   = PULSE_LOAD;
            tmo_nxt     = '0;
            stb_nxt     = '0;
            attempt_nxt = 4'd1;
        end else begin
            case (state)
                ST_PULSE: begin
                    // attempt==0 in PULSE only happens straight out of rst_n.
                    if (attempt == 4'd0) begin
                        attempt_nxt = 4'd1;
                        pulse_nxt   = PULSE_LOAD;
                    end else if (pulse_cnt == '0) begin
                        state_nxt = ST_WAIT;
                        tmo_nxt   = TMO_LOAD;
                    end else begin
                        pulse_nxt = pulse_cnt - PULSE_ONE;
                    end
                end
                ST_WAIT: begin
                    if (lock_s) begin
                        state_nxt = ST_STABLE;
                        stb_nxt   = STB_LOAD;
                    end else if (tmo_cnt == '0) begin
                        if (attempt < RETRY_MAX) begin
                            state_nxt   = ST_PULSE;
                            pulse_nxt   = PULSE_LOAD;
                            attempt_nxt = attempt + 4'd1;
                        end else begin
                            state_nxt = ST_FAIL;
                        end
                    end else begin
                        tmo_nxt = tmo_cnt - TMO_ONE;
                    end
                end
                ST_STABLE: begin
                    // Lock loss is tested first so it beats the terminal count.
                    if (!lock_s) begin
                        state_nxt = ST_WAIT;
                        stb_nxt   = '0;
                        tmo_nxt   = TMO_LOAD;
                    end else if (stb_cnt == '0) begin
                        state_nxt   = ST_RUN;
                        attempt_nxt = 4'd0;
                    end else begin
                        stb_nxt = stb_cnt - STB_ONE;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_nxt   = ST_PULSE;
                        pulse_nxt   = PULSE_LOAD;
                        attempt_nxt = 4'd1;
                    end
                end
                ST_FAIL: begin
                    state_nxt = ST_FAIL;
                end
                default: begin
                    state_nxt   = ST_PULSE;
                    attempt_nxt = 4'd0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_PULSE;
            pulse_cnt <= '0;
            tmo_cnt   <= '0;
            stb_cnt   <= '0;
            attempt   <= 4'd0;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pulse_cnt <= pulse_nxt;
            tmo_cnt   <= tmo_nxt;
            stb_cnt   <= stb_nxt;
            attempt   <= attempt_nxt;
            pll_reset <= (state_nxt == ST_PULSE) || (state_nxt == ST_FAIL);
            sys_rst_n <= (state_nxt == ST_RUN);
            locked    <= (state_nxt == ST_RUN);
            fail      <= (state_nxt == ST_FAIL);
        end
    end

endmodule
